// File: rtl/alu_byte_sequencer.sv
// alu_byte_sequencer
//   Feeds an NBYTES-wide operation into an external 8-bit arithmetic unit one
//   byte pair per cycle, LSB first.  The unit's carry-out is chained back as
//   the next byte's carry-in.  Result bytes, the final carry and an aggregate
//   zero flag are collected, and completion is signalled by a one-cycle done.
//
// Ports
//   clk, rst             clock (rising edge), synchronous active-high reset
//   start, op, cin_in    operation request (accepted only in IDLE), select, carry-in
//   opa, opb             W-bit operands, W = 8*NBYTES
//   busy, done           RUN indicator, one-cycle completion pulse
//   result, cout_out,    assembled result, MS-byte carry-out, all-bytes-zero flag
//   zero_out
//   au_a, au_b, au_s,    byte operands, select and carry-in to the arithmetic unit
//   au_cin
//   au_d, au_cout, au_z  result byte, carry-out and zero flag from the unit
//   carry_vec            per-byte carry-out vector (only with ALU_SEQ_CARRY_VEC_EN)
//
// Optional feature macro: ALU_SEQ_CARRY_VEC_EN
module alu_byte_sequencer #(
  parameter int NBYTES = 4,
  parameter int IDXW   = 2,
  parameter int W      = 8*NBYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic              cin_in,
  input  logic [W-1:0]      opa,
  input  logic [W-1:0]      opb,
  output logic              busy,
  output logic              done,
  output logic [W-1:0]      result,
  output logic              cout_out,
  output logic              zero_out,
`ifdef ALU_SEQ_CARRY_VEC_EN
  output logic [NBYTES-1:0] carry_vec,
`endif
  output logic [7:0]        au_a,
  output logic [7:0]        au_b,
  output logic [1:0]        au_s,
  output logic              au_cin,
  input  logic [7:0]        au_d,
  input  logic              au_cout,
  input  logic              au_z
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES-1);

  state_t            r_state, w_next;
  logic [IDXW-1:0]   r_idx;
  logic [W-1:0]      r_opa, r_opb;
  logic [1:0]        r_op;
  logic              r_carry;
  logic              r_zacc;
  logic [W-1:0]      r_result;
  logic              r_cout;
  logic              r_zero;
  logic              w_accept;
  logic              w_last;
`ifdef ALU_SEQ_CARRY_VEC_EN
  logic [NBYTES-1:0] r_carry_vec;
`endif

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_last   = (r_idx == LAST_IDX);

  // Next-state and combinational outputs
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    au_a   = 8'd0;
    au_b   = 8'd0;
    au_cin = 1'b0;
    au_s   = r_op;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_RUN;
      ST_RUN: begin
        busy   = 1'b1;
        au_a   = r_opa[8*r_idx +: 8];
        au_b   = r_opb[8*r_idx +: 8];
        au_cin = r_carry;
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_op     <= '0;
      r_carry  <= 1'b0;
      r_zacc   <= 1'b1;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_opa   <= opa;
        r_opb   <= opb;
        r_op    <= op;
        r_carry <= cin_in;
        r_idx   <= '0;
        r_zacc  <= 1'b1;
      end else if (r_state == ST_RUN) begin
        // Unwritten bytes keep their old value until their cycle comes up.
        r_result[8*r_idx +: 8] <= au_d;
        r_carry                <= au_cout;
        r_zacc                 <= r_zacc & au_z;
        if (w_last) begin
          r_cout <= au_cout;
          r_zero <= r_zacc & au_z;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

`ifdef ALU_SEQ_CARRY_VEC_EN
  always_ff @(posedge clk) begin
    if (rst)                     r_carry_vec        <= '0;
    else if (w_accept)           r_carry_vec        <= '0;
    else if (r_state == ST_RUN)  r_carry_vec[r_idx] <= au_cout;
  end
  assign carry_vec = r_carry_vec;
`endif

  assign result   = r_result;
  assign cout_out = r_cout;
  assign zero_out = r_zero;

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Directed bench for alu_byte_sequencer (NBYTES=4) with a behavioural
// add-with-carry arithmetic unit: D = A+B+cin, cout = carry, z = (D==0).
module tb_alu_byte_sequencer;
  localparam int NB = 4;
  localparam int W  = 8*NB;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic          cin_in;
  logic [W-1:0]  opa, opb;
  logic          busy, done, cout_out, zero_out;
  logic [W-1:0]  result;
  logic [7:0]    au_a, au_b, au_d;
  logic [1:0]    au_s;
  logic          au_cin, au_cout, au_z;
  logic [8:0]    w_sum;
`ifdef ALU_SEQ_CARRY_VEC_EN
  logic [NB-1:0] carry_vec;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic cin_log [NB];

  always #5 clk = ~clk;

  assign w_sum   = {1'b0, au_a} + {1'b0, au_b} + {8'd0, au_cin};
  assign au_d    = w_sum[7:0];
  assign au_cout = w_sum[8];
  assign au_z    = (w_sum[7:0] == 8'd0);

  alu_byte_sequencer #(.NBYTES(NB), .IDXW(2)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .cin_in(cin_in),
    .opa(opa), .opb(opb), .busy(busy), .done(done), .result(result),
    .cout_out(cout_out), .zero_out(zero_out),
`ifdef ALU_SEQ_CARRY_VEC_EN
    .carry_vec(carry_vec),
`endif
    .au_a(au_a), .au_b(au_b), .au_s(au_s), .au_cin(au_cin),
    .au_d(au_d), .au_cout(au_cout), .au_z(au_z)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start one operation and check the full busy/done timeline and results.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic [W-1:0] er, input logic ec, input logic ez,
                        input string tag);
    @(negedge clk); opa = a; opb = b; cin_in = ci; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_nodone"}, 64'(done), 64'd0);
      chk({tag, "_au_s"}, 64'(au_s), 64'(op));
      cin_log[i] = au_cin;
    end
    @(negedge clk);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy_off"}, 64'(busy), 64'd0);
    chk({tag, "_result"}, 64'(result), 64'(er));
    chk({tag, "_cout"}, 64'(cout_out), 64'(ec));
    chk({tag, "_zero"}, 64'(zero_out), 64'(ez));
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 64'(done), 64'd0);
    chk({tag, "_au_cin_idle"}, 64'(au_cin), 64'd0);
  endtask

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; op = 2'd1; cin_in = 1'b0; opa = '0; opb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_cout", 64'(cout_out), 64'd0);
    chk("rst_zero", 64'(zero_out), 64'd0);
    chk("rst_au_a", 64'(au_a), 64'd0);
    rst = 1'b0;

    // 1: carry ripples out of byte 0 only
    run_op(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, "t1");
`ifdef ALU_SEQ_CARRY_VEC_EN
    chk("t1_cvec", 64'(carry_vec), 64'h1);
`endif

    // 2: carry through every byte, all-zero result
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1, "t2");
`ifdef ALU_SEQ_CARRY_VEC_EN
    chk("t2_cvec", 64'(carry_vec), 64'hF);
`endif

    // 3: only the external carry-in contributes
    run_op(32'h0, 32'h0, 1'b1, 32'h00000001, 1'b0, 1'b0, "t3");
    chk("t3_cin0", 64'(cin_log[0]), 64'd1);
    chk("t3_cin1", 64'(cin_log[1]), 64'd0);
    chk("t3_cin3", 64'(cin_log[3]), 64'd0);

    // 4: start pulses during RUN and DONE are ignored
    @(negedge clk); opa = 32'h000000FF; opb = 32'h00000001; cin_in = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) ndone++;
      if (c == 2 || c == 5) begin opa = 32'h12345678; start = 1'b1; end
      if (c == 6) chk("t4_idle_after", 64'(busy), 64'd0);
    end
    start = 1'b0;
    chk("t4_one_done", 64'(ndone), 64'd1);
    chk("t4_result", 64'(result), 64'h00000100);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1, "t4b");

    // 5: reset in the second RUN cycle discards the operation
    @(negedge clk); opa = 32'hFFFFFFFF; opb = 32'h00000001; cin_in = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);               // first RUN cycle
    @(negedge clk); rst = 1'b1;   // second RUN cycle
    @(negedge clk); rst = 1'b0;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_result", 64'(result), 64'd0);
    chk("t5_cout", 64'(cout_out), 64'd0);
    chk("t5_zero", 64'(zero_out), 64'd0);
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("t5_no_done", 64'(ndone), 64'd0);
    run_op(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, "t5b");
`ifdef ALU_SEQ_CARRY_VEC_EN
    chk("t5b_cvec", 64'(carry_vec), 64'h1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
